ex_pipe: RTL and testbench
==========================

// Module: ex_pipe
// PURPOSE
//  Parametrised, pipelined execute stage for the next-generation WISC core.
//  Selects src1 (register or sign-extended immediate) and runs the ALU op.
//  Registers result, store data and N/Z/V flags behind valid/ready handshakes, so the stage can stall and flush.
//  Sits between decode/regfile read and the memory stage.
// PARAMETERS
//  WIDTH    16  datapath width in bits (>=8)
//  IMM_W    8   immediate width; sign-extended to WIDTH (IMM_W < WIDTH)
//  SHAMT_W  4   shift-amount width; equals clog2(WIDTH)
// PORTS
//  clk       in   1        clock, rising edge
//  rst       in   1        asynchronous reset, active-high
//  flush     in   1        synchronous kill of in-flight/held op
//  in_valid  in   1        op presented on input bus
//  in_ready  out  1        stage can accept op this cycle
//  func      in   3        000 ADD,001 SUB,010 AND,011 NOR,100 SLL,101 SRL,110 SRA,111 LLB
//  src1sel   in   1        1: src1=sext(imm); 0: src1=p1
//  p0        in   WIDTH    src0 operand
//  p1        in   WIDTH    src1 register operand / store data
//  imm       in   IMM_W    immediate
//  shamt     in   SHAMT_W  shift amount
//  out_valid out  1        dst/sdata valid
//  out_ready in   1        downstream accepts result
//  dst       out  WIDTH    registered result
//  sdata     out  WIDTH    registered p1 (store data)
//  N,Z,V     out  1        architectural flag register
// BEHAVIOUR
//  - Reset: out_valid=0, dst=0, sdata=0, N=Z=V=0, FSM=IDLE; in_ready=1 after reset.
//  - Accept = in_valid & in_ready. in_ready = (FSM==IDLE) & (!out_valid | out_ready).
//  - Latency: single-cycle ops write dst/sdata and set out_valid at the edge after accept.
//  - out_valid holds and dst/sdata hold stable until out_ready=1. Back-to-back throughput is 1 op/cycle.
//  - Arithmetic: ADD = src0+src1 and SUB = src0-src1, both saturating.
//    Positive overflow gives 0111..1; negative overflow gives 1000..0; V=1 on either.
//  - AND = src0&src1; NOR = ~(src0|src1).
//  - Shifts use src0 and shamt; SRA replicates the MSB; shamt=0 passes src0.
//  - LLB = sext(imm).
//  - Flags update at the same edge dst is written, never on a stalled cycle:
//    ADD/SUB write N (MSB of saturated result), Z (result==0) and V;
//    AND/NOR/shifts write Z only; LLB writes no flags.
//  - flush: clears out_valid and returns FSM to IDLE at the next edge.
//    The killed op writes no flags; dst/sdata keep their old values.
//    flush with a simultaneous accept drops the new op; flush has priority.
//  - rst asserted mid-operation: all state returns to reset values immediately.
//  - FSM (iterative mode only): IDLE -> SHIFT on accept of a shift with shamt>1;
//    SHIFT stays for shamt-1 further cycles, one bit per cycle;
//    SHIFT -> IDLE when the count reaches 0, writing dst and flags and setting out_valid.
// CONFIGURATION
//  EX_ITER_SHIFT_EN defined: shifts use a 1-bit/cycle iterative shifter.
//    Latency is max(1,shamt) cycles and in_ready=0 while in SHIFT.
//  EX_ITER_SHIFT_EN undefined: single-cycle barrel shifter and no SHIFT state.
//    All ops have 1-cycle latency.
// TESTING
//  - rst=1 mid-run, then release -> out_valid=0, dst=0, NZV=000, in_ready=1 the next cycle.
//  - ADD p0=16'h7FFF, imm=8'h01, src1sel=1 -> dst=16'h7FFF, N=0, Z=0, V=1 one cycle after accept.
//  - SUB p0=16'h8000, p1=16'h0001 -> dst=16'h8000, N=1, V=1.
//    Then AND 16'h00F0 & 16'h0F00 -> dst=0, Z=1, N=1 and V=1 unchanged.
//  - out_ready=0 for 3 cycles with out_valid=1 -> dst, sdata, NZV stable and in_ready=0;
//    the next op is accepted in the cycle out_ready=1.
//  - flush with in_valid=1 and an op held -> out_valid=0 next edge, NZV unchanged, new op dropped.
//  - EX_ITER_SHIFT_EN: SRA p0=16'h8000, shamt=4 -> in_ready=0 for 3 cycles,
//    then dst=16'hF800, Z=0, out_valid=1 four cycles after accept.

Source files
------------

// File: rtl/ex_pipe.sv
// Execute stage: src1 select, saturating ALU, N/Z/V flags, valid/ready output register.
// Define EX_ITER_SHIFT_EN for a 1-bit/cycle iterative shifter instead of the barrel shifter.
module ex_pipe #(
   parameter int WIDTH   = 16,
   parameter int IMM_W   = 8,
   parameter int SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         func,
   input  logic               src1sel,
   input  logic [WIDTH-1:0]   p0,
   input  logic [WIDTH-1:0]   p1,
   input  logic [IMM_W-1:0]   imm,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   dst,
   output logic [WIDTH-1:0]   sdata,
   output logic               N,
   output logic               Z,
   output logic               V
);

   localparam logic [2:0] F_ADD = 3'b000, F_SUB = 3'b001, F_AND = 3'b010, F_NOR = 3'b011,
                          F_SLL = 3'b100, F_SRL = 3'b101, F_SRA = 3'b110, F_LLB = 3'b111;
   localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MAXN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] w_imm_sx, w_src1, w_sum, w_diff, w_sat, w_shift, w_res;
   logic             w_add_ov, w_sub_ov, w_v, w_wr_nv, w_wr_z;
   logic             w_idle, w_accept, w_go_iter;

   assign w_imm_sx = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
   assign w_src1   = src1sel ? w_imm_sx : p1;
   assign w_sum    = p0 + w_src1;
   assign w_diff   = p0 - w_src1;
   assign w_add_ov = (p0[WIDTH-1] == w_src1[WIDTH-1]) && (w_sum[WIDTH-1]  != p0[WIDTH-1]);
   assign w_sub_ov = (p0[WIDTH-1] != w_src1[WIDTH-1]) && (w_diff[WIDTH-1] != p0[WIDTH-1]);
   // On overflow the true result always has the sign of src0, so clamp toward it
   assign w_sat    = p0[WIDTH-1] ? MAXN : MAXP;

`ifdef EX_ITER_SHIFT_EN
   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_acc, r_p1, w_step;
   logic [SHAMT_W-1:0] r_cnt;
   logic [2:0]         r_fn;
   logic               w_is_shift;

   function automatic logic [WIDTH-1:0] f_shift1(input logic [2:0] fn, input logic [WIDTH-1:0] a);
      case (fn)
         F_SLL:   f_shift1 = {a[WIDTH-2:0], 1'b0};
         F_SRL:   f_shift1 = {1'b0, a[WIDTH-1:1]};
         default: f_shift1 = {a[WIDTH-1], a[WIDTH-1:1]};
      endcase
   endfunction

   assign w_is_shift = (func == F_SLL) || (func == F_SRL) || (func == F_SRA);
   assign w_idle     = (r_state == S_IDLE);
   assign w_go_iter  = w_accept && w_is_shift && (shamt > SHAMT_W'(1));
   assign w_step     = f_shift1(r_fn, r_acc);
   // shamt 0/1 still complete in one cycle; longer shifts divert to the SHIFT state
   assign w_shift    = (shamt == '0) ? p0 : f_shift1(func, p0);
`else
   assign w_idle    = 1'b1;
   assign w_go_iter = 1'b0;
   always_comb begin
      case (func)
         F_SLL:   w_shift = p0 << shamt;
         F_SRL:   w_shift = p0 >> shamt;
         default: w_shift = $signed(p0) >>> shamt;
      endcase
   end
`endif

   assign in_ready = w_idle && (!out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_res   = '0;
      w_v     = 1'b0;
      w_wr_nv = 1'b0;
      w_wr_z  = 1'b0;
      case (func)
         F_ADD: begin
            w_res   = w_add_ov ? w_sat : w_sum;
            w_v     = w_add_ov;
            w_wr_nv = 1'b1;
            w_wr_z  = 1'b1;
         end
         F_SUB: begin
            w_res   = w_sub_ov ? w_sat : w_diff;
            w_v     = w_sub_ov;
            w_wr_nv = 1'b1;
            w_wr_z  = 1'b1;
         end
         F_AND: begin
            w_res  = p0 & w_src1;
            w_wr_z = 1'b1;
         end
         F_NOR: begin
            w_res  = ~(p0 | w_src1);
            w_wr_z = 1'b1;
         end
         F_SLL, F_SRL, F_SRA: begin
            w_res  = w_shift;
            w_wr_z = 1'b1;
         end
         default: w_res = w_imm_sx;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         dst       <= '0;
         sdata     <= '0;
         N         <= 1'b0;
         Z         <= 1'b0;
         V         <= 1'b0;
`ifdef EX_ITER_SHIFT_EN
         r_state   <= S_IDLE;
         r_acc     <= '0;
         r_p1      <= '0;
         r_cnt     <= '0;
         r_fn      <= F_SLL;
`endif
      end else if (flush) begin
         out_valid <= 1'b0;
`ifdef EX_ITER_SHIFT_EN
         r_state   <= S_IDLE;
`endif
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (w_accept && !w_go_iter) begin
            dst       <= w_res;
            sdata     <= p1;
            out_valid <= 1'b1;
            if (w_wr_nv) begin
               N <= w_res[WIDTH-1];
               V <= w_v;
            end
            if (w_wr_z)
               Z <= (w_res == '0);
         end
`ifdef EX_ITER_SHIFT_EN
         if (w_go_iter) begin
            r_state <= S_SHIFT;
            r_acc   <= f_shift1(func, p0);
            r_cnt   <= shamt - SHAMT_W'(1);
            r_fn    <= func;
            r_p1    <= p1;
         end
         if (r_state == S_SHIFT) begin
            if (r_cnt == SHAMT_W'(1)) begin
               dst       <= w_step;
               sdata     <= r_p1;
               Z         <= (w_step == '0);
               out_valid <= 1'b1;
               r_state   <= S_IDLE;
            end else begin
               r_acc <= w_step;
               r_cnt <= r_cnt - SHAMT_W'(1);
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_ex_pipe.sv
// Directed bench for ex_pipe: latency-counter model compared every cycle, plus literal checks.
module tb_ex_pipe;

`ifdef EX_ITER_SHIFT_EN
   localparam bit ITER = 1'b1;
`else
   localparam bit ITER = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, src1sel = 1'b0;
   logic        in_ready, out_valid, N, Z, V;
   logic [2:0]  func = 3'd0;
   logic [15:0] p0 = 16'd0, p1 = 16'd0, dst, sdata;
   logic [7:0]  imm = 8'd0;
   logic [3:0]  shamt = 4'd0;

   int n_chk = 0, n_err = 0;

   ex_pipe #(.WIDTH(16), .IMM_W(8), .SHAMT_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .func(func), .src1sel(src1sel), .p0(p0), .p1(p1), .imm(imm), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready), .dst(dst), .sdata(sdata),
      .N(N), .Z(Z), .V(V));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference ALU in plain integer arithmetic; kind: 0 no flags, 1 Z only, 2 N/Z/V
   function automatic void ref_alu(input logic [2:0] fn, input logic sel, input logic [15:0] a, b,
                                   input logic [7:0] im, input logic [3:0] sh,
                                   output logic [15:0] r, output logic rv, output int kind);
      logic signed [7:0] ims;
      int sa, sb, s;
      logic [15:0] s1;
      ims = im;
      sa  = $signed(a);
      sb  = sel ? int'(ims) : int'($signed(b));
      s1  = 16'(sb);
      rv  = 1'b0;
      kind = 1;
      r   = 16'd0;
      case (fn)
         3'd0, 3'd1: begin
            s = (fn == 3'd0) ? sa + sb : sa - sb;
            kind = 2;
            if (s > 32767)       begin r = 16'h7FFF; rv = 1'b1; end
            else if (s < -32768) begin r = 16'h8000; rv = 1'b1; end
            else                 r = 16'(s);
         end
         3'd2: r = a & s1;
         3'd3: r = ~(a | s1);
         3'd4: r = 16'(a << sh);
         3'd5: r = a >> sh;
         3'd6: r = 16'(sa >>> sh);
         default: begin r = 16'(int'(ims)); kind = 0; end
      endcase
   endfunction

   // Model state: visible outputs plus a countdown for multi-cycle shifts
   logic        m_ov, m_n, m_z, m_v, acc, rv;
   logic [15:0] m_dst, m_sd, p_dst, p_sd, r;
   int          m_busy, lat, kind;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ov = 0; m_dst = 0; m_sd = 0; m_n = 0; m_z = 0; m_v = 0; m_busy = 0;
      end else if (flush) begin
         m_ov = 0; m_busy = 0;
      end else begin
         acc = in_valid && (m_busy == 0) && (!m_ov || out_ready);
         if (m_ov && out_ready) m_ov = 0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_dst = p_dst; m_sd = p_sd; m_z = (p_dst == 0); m_ov = 1;
            end
         end
         if (acc) begin
            ref_alu(func, src1sel, p0, p1, imm, shamt, r, rv, kind);
            lat = (ITER && func >= 3'd4 && func <= 3'd6 && shamt > 1) ? int'(shamt) : 1;
            if (lat == 1) begin
               m_dst = r; m_sd = p1; m_ov = 1;
               if (kind == 2) begin m_n = r[15]; m_v = rv; end
               if (kind >= 1) m_z = (r == 0);
            end else begin
               m_busy = lat - 1; p_dst = r; p_sd = p1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready",  in_ready,  (m_busy == 0) && (!m_ov || out_ready));
         chk("out_valid", out_valid, m_ov);
         chk("dst",       dst,       m_dst);
         chk("sdata",     sdata,     m_sd);
         chk("nzv",       {N, Z, V}, {m_n, m_z, m_v});
      end
   end

   // Presents an op and returns #1 after the edge that accepted it; in_valid stays high
   task automatic op(input logic [2:0] fn, input logic sel, input logic [15:0] a, b,
                     input logic [7:0] im, input logic [3:0] sh);
      bit ok;
      ok = 0;
      func = fn; src1sel = sel; p0 = a; p1 = b; imm = im; shamt = sh; in_valid = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         n_chk++; n_err++;
         $display("FAIL accept_timeout: in_ready never rose at %0t", $time);
         in_valid = 0;
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_out();
      bit ok;
      ok = 0;
      in_valid = 0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (!ok) begin
         n_chk++; n_err++;
         $display("FAIL result_timeout: out_valid never rose at %0t", $time);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dst", dst, 16'h0000);
      chk("rst_nzv", {N, Z, V}, 3'b000);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Back-to-back arithmetic/logic ops
      op(3'd0, 1, 16'h7FFF, 16'h0000, 8'h01, 0);
      chk("add_sat_dst", dst, 16'h7FFF); chk("add_sat_nzv", {N, Z, V}, 3'b001);
      chk("add_sat_ov", out_valid, 1);
      op(3'd1, 0, 16'h8000, 16'h0001, 8'h00, 0);
      chk("sub_sat_dst", dst, 16'h8000); chk("sub_sat_nzv", {N, Z, V}, 3'b101);
      op(3'd2, 0, 16'h00F0, 16'h0F00, 8'h00, 0);
      chk("and_dst", dst, 16'h0000); chk("and_nzv", {N, Z, V}, 3'b111);
      chk("and_sdata", sdata, 16'h0F00);
      op(3'd0, 0, 16'h8000, 16'hFFFF, 8'h00, 0);
      chk("add_negsat_dst", dst, 16'h8000); chk("add_negsat_nzv", {N, Z, V}, 3'b101);
      op(3'd0, 0, 16'h0003, 16'h0004, 8'h00, 0);
      chk("add_dst", dst, 16'h0007); chk("add_nzv", {N, Z, V}, 3'b000);
      op(3'd1, 0, 16'h0005, 16'h0005, 8'h00, 0);
      chk("sub_zero_nzv", {N, Z, V}, 3'b010);
      op(3'd3, 0, 16'h0000, 16'h0000, 8'h00, 0);
      chk("nor_dst", dst, 16'hFFFF); chk("nor_nzv", {N, Z, V}, 3'b000);
      op(3'd7, 0, 16'h1234, 16'h5678, 8'h80, 0);
      chk("llb_dst", dst, 16'hFF80); chk("llb_nzv", {N, Z, V}, 3'b000);
      chk("llb_sdata", sdata, 16'h5678);
      op(3'd0, 1, 16'h0000, 16'h0000, 8'hFF, 0);
      chk("add_immneg_dst", dst, 16'hFFFF); chk("add_immneg_nzv", {N, Z, V}, 3'b100);

      // Shifts (latency depends on build, so wait for the result)
      op(3'd4, 0, 16'h0001, 16'h0000, 8'h00, 15); wait_out();
      chk("sll15_dst", dst, 16'h8000); chk("sll15_nzv", {N, Z, V}, 3'b100);
      op(3'd5, 0, 16'h8000, 16'h0000, 8'h00, 4); wait_out();
      chk("srl4_dst", dst, 16'h0800);
      op(3'd6, 0, 16'h8000, 16'h0000, 8'h00, 4); wait_out();
      chk("sra4_dst", dst, 16'hF800); chk("sra4_z", Z, 0);
      op(3'd6, 0, 16'h7FF0, 16'h0000, 8'h00, 0); wait_out();
      chk("sra0_dst", dst, 16'h7FF0);
      op(3'd6, 0, 16'h0001, 16'h0000, 8'h00, 1); wait_out();
      chk("sra1_dst", dst, 16'h0000); chk("sra1_nzv", {N, Z, V}, 3'b110);
      idle(1);

`ifdef EX_ITER_SHIFT_EN
      op(3'd6, 0, 16'h8000, 16'h0000, 8'h00, 4);
      in_valid = 0;
      repeat (3) begin @(negedge clk); chk("iter_busy_rdy", in_ready, 0); chk("iter_busy_ov", out_valid, 0); end
      @(posedge clk); #1;
      chk("iter_sra_dst", dst, 16'hF800); chk("iter_sra_ov", out_valid, 1);
      idle(1);
`endif

      // Output stall: result held, next op waits
      out_ready = 0;
      op(3'd0, 0, 16'h0001, 16'h0001, 8'h00, 0);
      func = 3'd0; p0 = 16'h0003; p1 = 16'h0004;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0); chk("stall_dst", dst, 16'h0002);
         chk("stall_sdata", sdata, 16'h0001); chk("stall_nzv", {N, Z, V}, 3'b000);
      end
      @(posedge clk); #1 out_ready = 1;
      @(negedge clk); chk("unstall_in_ready", in_ready, 1);
      @(posedge clk); #1 in_valid = 0;
      chk("unstall_dst", dst, 16'h0007); chk("unstall_ov", out_valid, 1);
      idle(1);

      // Flush with a held result and a simultaneous accept
      out_ready = 0;
      op(3'd1, 0, 16'h0000, 16'h0001, 8'h00, 0);
      func = 3'd0; p0 = 16'h0000; p1 = 16'h0000; out_ready = 1; flush = 1;
      @(posedge clk); #1 flush = 0; in_valid = 0;
      chk("flush_ov", out_valid, 0); chk("flush_dst", dst, 16'hFFFF);
      chk("flush_nzv", {N, Z, V}, 3'b100);
      idle(3);
      chk("flush_dropped", out_valid, 0);

      // Asynchronous reset mid-run
      out_ready = 0;
      op(3'd0, 1, 16'h7FFF, 16'h0000, 8'h01, 0);
      in_valid = 0;
      #1 rst = 1;
      #1;
      chk("arst_ov", out_valid, 0); chk("arst_dst", dst, 16'h0000);
      chk("arst_sdata", sdata, 16'h0000); chk("arst_nzv", {N, Z, V}, 3'b000);
      @(posedge clk); #1 rst = 0; out_ready = 1;
      @(negedge clk);
      chk("arst_in_ready", in_ready, 1); chk("arst_ov2", out_valid, 0);
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
